// File: rtl/board_row_fetcher.sv
// board_row_fetcher
//   Row-fetch scheduler and board-RAM arbiter for the display path. On the
//   horizontal-sync falling edge that precedes a new block row, it reads that
//   row's BOARD_COLS cells from the single-port board RAM into a shadow
//   buffer. It then commits them all at once to Row, which color_mapper
//   consumes, so Row never changes while a block row is being drawn. Game
//   logic shares the RAM but only gets it while no fetch is in progress.
//
// Ports
//   Clk, reset      system clock; synchronous active-high reset
//   hs              VGA horizontal sync (active low)
//   DrawY           current scanline, 0..524
//   mem_*           board RAM port; read data arrives one cycle after address
//   game_*          single-access request from game logic; game_gnt=1 in the
//                   cycle the access is driven onto the RAM
//   Row, rowNum     committed row cells (index = column) and their board row
//   row_valid       one-cycle pulse after each commit
//   fetch_overrun   sticky: a trigger arrived while a fetch was still running
module board_row_fetcher #(
  parameter int SQUARE_SIZE = 21,
  parameter int BOARD_COLS  = 10,
  parameter int BOARD_ROWS  = 20,
  parameter int CELL_W      = 16
) (
  input  logic                             Clk,
  input  logic                             reset,
  input  logic                             hs,
  input  logic [9:0]                       DrawY,
  output logic [7:0]                       mem_addr,
  output logic                             mem_we,
  output logic [CELL_W-1:0]                mem_wdata,
  input  logic [CELL_W-1:0]                mem_rd_data,
  input  logic                             game_req,
  input  logic                             game_we,
  input  logic [7:0]                       game_addr,
  input  logic [CELL_W-1:0]                game_wdata,
  output logic                             game_gnt,
  output logic [BOARD_COLS-1:0][CELL_W-1:0] Row,
  output logic [7:0]                       rowNum,
  output logic                             row_valid,
  output logic                             fetch_overrun
);

  localparam int COL_W = $clog2(BOARD_COLS);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(BOARD_COLS - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, COMMIT} state_t;

  state_t state, state_next;

  logic                              hs_q;
  logic [COL_W-1:0]                  col;
  logic [7:0]                        target;
  logic [7:0]                        base;
  logic                              cap_valid;
  logic [COL_W-1:0]                  cap_col;
  logic [BOARD_COLS-1:0][CELL_W-1:0] shadow;

  // Trigger decode. The next scanline is formed in 11 bits, so scanline 524
  // cannot wrap; 524 itself is handled separately as the next-frame prefetch
  // of row 0.
  logic [10:0] line_next;
  logic [7:0]  blk_row;
  logic        aligned;
  logic        hs_fall;
  logic        trigger;
  logic [7:0]  trig_target;
  logic [7:0]  trig_base;

  // NOTE: every signal driven from always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    line_next   = {1'b0, DrawY} + 11'd1;
    blk_row     = 8'(line_next / 11'(SQUARE_SIZE));
    aligned     = ((line_next % 11'(SQUARE_SIZE)) == 11'd0) &&
                  (blk_row < 8'(BOARD_ROWS));
    hs_fall     = hs_q && !hs;
    trigger     = !reset && hs_fall && ((DrawY == 10'd524) || aligned);
    trig_target = (DrawY == 10'd524) ? 8'd0 : blk_row;
    trig_base   = 8'(trig_target * 8'(BOARD_COLS));
  end

  // Next state plus RAM port mux. The display fetch owns the RAM from the
  // trigger cycle until the FSM is back in IDLE; a game request made in a
  // trigger cycle is simply not granted and is expected to be held.
  always_comb begin
    state_next = state;
    mem_addr   = 8'd0;
    mem_we     = 1'b0;
    mem_wdata  = '0;
    game_gnt   = 1'b0;
    if (!reset) begin
      unique case (state)
        IDLE: begin
          if (trigger) begin
            state_next = FETCH;
          end else if (game_req) begin
            game_gnt  = 1'b1;
            mem_addr  = game_addr;
            mem_we    = game_we;
            mem_wdata = game_wdata;
          end
        end
        FETCH: begin
          mem_addr = base + 8'(col);
          if (col == LAST_COL) state_next = DRAIN;
        end
        DRAIN:   state_next = COMMIT;
        COMMIT:  state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge Clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      hs_q          <= 1'b1;
      col           <= '0;
      target        <= 8'd0;
      base          <= 8'd0;
      cap_valid     <= 1'b0;
      cap_col       <= '0;
      // NOTE: shadow and Row are a few registers rather than a RAM macro, so clearing them on reset is cheap and keeps state deterministic.
      shadow        <= '0;
      Row           <= '0;
      rowNum        <= 8'd0;
      row_valid     <= 1'b0;
      fetch_overrun <= 1'b0;
    end else begin
      hs_q      <= hs;
      row_valid <= 1'b0;
      cap_valid <= 1'b0;

      // A trigger while busy is dropped; the running fetch is unaffected.
      if (trigger && state != IDLE) fetch_overrun <= 1'b1;

      if (state == IDLE && trigger) begin
        target <= trig_target;
        base   <= trig_base;
        col    <= '0;
      end

      // Remember which column this cycle's address belongs to; its data is
      // on mem_rd_data during the following cycle.
      if (state == FETCH) begin
        cap_valid <= 1'b1;
        cap_col   <= col;
        col       <= col + COL_W'(1);
      end

      if (cap_valid) shadow[cap_col] <= mem_rd_data;

      if (state == COMMIT) begin
        Row       <= shadow;
        rowNum    <= target;
        row_valid <= 1'b1;
      end
    end
  end

endmodule
